// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and fetch FSM encoding.
package cpu_pkg;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_STORE  = 3'b010;
   localparam logic [2:0] OP_EPAR   = 3'b100;
   localparam logic [2:0] OP_CP     = 3'b111;
   localparam logic [3:0] OP_JUMP   = 4'b0011;
   localparam logic [3:0] OP_BRANCH = 4'b0100;
   localparam logic [3:0] OP_HALT   = 4'b1011;

   localparam int FORMAT_BIT  = 8;
   localparam int OPCODE_MSB  = 7;
   localparam int OPCODE_LSB  = 4;
   localparam int SIGN_BIT    = 3;
   localparam int OPERAND_MSB = 3;
   localparam int OPERAND_LSB = 0;

   typedef enum logic [2:0] {
      S_FETCH,
      S_LATCH,
      S_DECODE,
      S_EXEC,
      S_HALTED
   } fetch_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with next-PC selection between PC+1 (wrapping) and a target.
module pc_unit #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                advance,
   input  logic                load_target,
   input  logic [PC_WIDTH-1:0] target,
   output logic [PC_WIDTH-1:0] pc
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (advance) begin
         pc <= load_target ? target : pc + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing: PC, instruction register, fetch FSM and retire counter.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                  PC_WIDTH    = 8,
   parameter int                  INSTR_WIDTH = 9,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [PC_WIDTH-1:0]    imem_addr,
   output logic                   imem_en,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic                   format,
   output logic [3:0]             opcode,
   output logic                   sign,
   output logic [3:0]             operand,
   output logic                   instr_valid,
   input  logic                   halt,
   input  logic                   branch,
   input  logic                   jump,
   input  logic                   branch_cond,
   input  logic [PC_WIDTH-1:0]    target,
   input  logic                   stall,
   output logic                   retire,
   output logic                   halted,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [15:0]            retired_count
);

   fetch_state_t           state;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   completing;

   // NOTE: reset gates the completion strobe so an abandoned EXEC never pulses retire.
   assign completing = (state == S_EXEC) && !stall && !reset;
   assign retire     = completing;
   assign imem_en    = (state == S_FETCH) && !reset;
   assign imem_addr  = pc;
   assign halted     = (state == S_HALTED);

   assign format  = ir[FORMAT_BIT];
   assign opcode  = ir[OPCODE_MSB:OPCODE_LSB];
   assign sign    = ir[SIGN_BIT];
   assign operand = ir[OPERAND_MSB:OPERAND_LSB];

   pc_unit #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .reset       (reset),
      .advance     (completing && !halt),
      .load_target (jump || (branch && branch_cond)),
      .target      (target),
      .pc          (pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FETCH;
         ir            <= '0;
         instr_valid   <= 1'b0;
         retired_count <= '0;
      end else begin
         unique case (state)
            S_FETCH:  state <= S_LATCH;
            S_LATCH: begin
               ir          <= imem_data;
               instr_valid <= 1'b1;
               state       <= S_DECODE;
            end
            S_DECODE: state <= S_EXEC;
            S_EXEC: begin
               // Control inputs are only honoured here; a stall freezes everything.
               if (!stall) begin
                  instr_valid   <= 1'b0;
                  retired_count <= sat_inc16(retired_count);
                  state         <= halt ? S_HALTED : S_FETCH;
               end
            end
            S_HALTED: state <= S_HALTED;
            default:  state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a behavioural PC/retire model.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] imem_addr;
   logic       imem_en;
   logic [8:0] imem_data;
   logic       format;
   logic [3:0] opcode;
   logic       sign;
   logic [3:0] operand;
   logic       instr_valid;
   logic       halt, branch, jump, branch_cond, stall;
   logic [7:0] target;
   logic       retire;
   logic       halted;
   logic [7:0] pc;
   logic [15:0] retired_count;

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_en       (imem_en),
      .imem_data     (imem_data),
      .format        (format),
      .opcode        (opcode),
      .sign          (sign),
      .operand       (operand),
      .instr_valid   (instr_valid),
      .halt          (halt),
      .branch        (branch),
      .jump          (jump),
      .branch_cond   (branch_cond),
      .target        (target),
      .stall         (stall),
      .retire        (retire),
      .halted        (halted),
      .pc            (pc),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   logic [8:0] mem [256];
   always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   typedef struct {
      logic [7:0]  pc;
      logic [8:0]  instr;
      int          lat;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  model_pc;
   logic [15:0] model_cnt;

   // Monitor: records each fetch, and on every retire pops the scoreboard and compares.
   logic [7:0] fetch_addr;
   int         fetch_cyc;
   exp_t       e;
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (imem_en) begin
            fetch_addr = imem_addr;
            fetch_cyc  = cyc;
         end
         if (retire) begin
            if (exp_q.size() == 0) begin
               check("unexpected_retire", 32'(retire), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("fetch_addr",   32'(fetch_addr),  32'(e.pc));
               check("pc_at_retire", 32'(pc),          32'(e.pc));
               check("format",       32'(format),      32'(e.instr[8]));
               check("opcode",       32'(opcode),      32'(e.instr[7:4]));
               check("sign",         32'(sign),        32'(e.instr[3]));
               check("operand",      32'(operand),     32'(e.instr[3:0]));
               check("instr_valid",  32'(instr_valid), 32'(1));
               check("latency",      32'(cyc - fetch_cyc + 1), 32'(e.lat));
               check("count",        32'(retired_count), 32'(e.cnt));
            end
         end
      end
   end

   task automatic noise();
      halt        = 1'($urandom_range(0, 1));
      jump        = 1'($urandom_range(0, 1));
      branch      = 1'($urandom_range(0, 1));
      branch_cond = 1'($urandom_range(0, 1));
      target      = 8'($urandom);
      stall       = 1'b0;
   endtask

   task automatic wait_decode(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 32 && !ok; i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) ok = 1'b1;
      end
      if (!ok) check("decode_timeout", 32'(0), 32'(1));
   endtask

   // Issues one instruction: pushes the expected outcome, then plays control for its EXEC.
   task automatic issue(input bit h, input bit j, input bit b, input bit c,
                        input logic [7:0] tgt, input int stall_n);
      exp_t x;
      bit   ok;
      x.pc    = model_pc;
      x.instr = mem[model_pc];
      x.lat   = 4 + stall_n;
      x.cnt   = model_cnt;
      exp_q.push_back(x);
      model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
      if (h)           model_pc = model_pc;
      else if (j)      model_pc = tgt;
      else if (b && c) model_pc = tgt;
      else             model_pc = model_pc + 8'd1;
      wait_decode(ok);
      if (!ok) return;
      halt = h; jump = j; branch = b; branch_cond = c; target = tgt;
      stall = (stall_n > 0);
      repeat (stall_n + 1) @(posedge clk);
      #1 stall = 1'b0;
      @(posedge clk);
      #1 noise();
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_imem_en",     32'(imem_en),       32'(0));
      check("rst_instr_valid", 32'(instr_valid),   32'(0));
      check("rst_retire",      32'(retire),        32'(0));
      check("rst_halted",      32'(halted),        32'(0));
      check("rst_pc",          32'(pc),            32'(0));
      check("rst_count",       32'(retired_count), 32'(0));
      check("rst_fields",      32'({format, opcode, sign, operand}), 32'(0));
      exp_q.delete();
      model_pc  = 8'h00;
      model_cnt = 16'h0000;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_imem_en",   32'(imem_en),   32'(1));
      check("post_rst_imem_addr", 32'(imem_addr), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  c0;
      bit  ok;
      reset = 1'b1;
      halt = 0; jump = 0; branch = 0; branch_cond = 0; stall = 0; target = '0;
      for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);

      apply_reset();

      // Sequential run: four plain instructions in 16 cycles.
      c0 = cyc;
      for (int i = 0; i < 4; i++) issue(0, 0, 0, 0, 8'($urandom), 0);
      check("seq_cycles", 32'(cyc - c0), 32'(16));
      check("seq_count",  32'(retired_count), 32'(4));

      // Jump, then branch not-taken and taken.
      issue(0, 1, 0, 0, 8'h40, 0);
      issue(0, 0, 0, 0, 8'h00, 0);
      issue(0, 1, 0, 0, 8'h10, 0);
      issue(0, 0, 1, 0, 8'h33, 0);
      issue(0, 0, 1, 1, 8'h05, 0);
      issue(0, 0, 0, 0, 8'h00, 0);

      // Wrap from 0xFF to 0x00.
      issue(0, 1, 0, 0, 8'hFF, 0);
      issue(0, 0, 0, 0, 8'h12, 0);
      issue(0, 0, 0, 0, 8'h00, 0);

      // Random mix of jumps, branches and stalls.
      for (int i = 0; i < 40; i++) begin
         issue(0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      // Saturation of the retire counter.
      force dut.retired_count = 16'hFFFE;
      #1 release dut.retired_count;
      model_cnt = 16'hFFFE;
      for (int i = 0; i < 3; i++) issue(0, 0, 0, 0, 8'($urandom), 0);
      check("sat_count", 32'(retired_count), 32'hFFFF);

      // Reset while an instruction sits in DECODE.
      wait_decode(ok);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      model_pc  = 8'h00;
      model_cnt = 16'h0000;
      @(negedge clk);
      check("midrst_imem_en",   32'(imem_en),       32'(1));
      check("midrst_imem_addr", 32'(imem_addr),     32'(0));
      check("midrst_retire",    32'(retire),        32'(0));
      check("midrst_count",     32'(retired_count), 32'(0));
      check("midrst_valid",     32'(instr_valid),   32'(0));
      issue(0, 0, 0, 0, 8'h00, 0);
      issue(0, 1, 0, 0, 8'h80, 0);

      // Halt (with jump also asserted) after a 3-cycle stall; HALTED ignores all inputs.
      issue(1, 1, 0, 0, 8'h22, 3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("halted",        32'(halted),        32'(1));
         check("halt_imem_en",  32'(imem_en),       32'(0));
         check("halt_pc",       32'(pc),            32'(model_pc));
         check("halt_count",    32'(retired_count), 32'(model_cnt));
         noise();
      end
      check("halt_queue_drained", 32'(exp_q.size()), 32'(0));

      // Recovery from HALTED through reset.
      apply_reset();
      issue(0, 0, 0, 0, 8'h00, 0);
      issue(0, 0, 0, 0, 8'h00, 0);
      check("final_count", 32'(retired_count), 32'(2));
      check("final_queue", 32'(exp_q.size()),  32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing block for the single-cycle-issue CPU. It holds the program counter, reads 9-bit instructions from the synchronous instruction memory and splits each one into the `format`, `opcode` and `sign` fields that feed `control`. It then samples the registered `halt`, `branch` and `jump` outputs from `control` to choose the next PC. It sits between instruction memory and `control`, and runs a fixed multi-cycle fetch/decode/execute sequence.

## Interface
Parameters:
- `PC_WIDTH`, 8: program counter and instruction memory address width.
- `INSTR_WIDTH`, 9: instruction width. Fixed at 9; any other value is illegal.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1: clock. This is the single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `imem_addr`  out  PC_WIDTH: instruction memory address.
- `imem_en`  out  1: instruction memory read enable.
- `imem_data`  in  9: instruction memory read data, valid 1 cycle after `imem_en`.
- `format`  out  1: instruction bit [8].
- `opcode`  out  4: instruction bits [7:4].
- `sign`  out  1: instruction bit [3].
- `operand`  out  4: instruction bits [3:0], for the datapath.
- `instr_valid`  out  1: the decoded fields hold a live instruction.
- `halt`  in  1: halt request from `control`.
- `branch`  in  1: branch request from `control`.
- `jump`  in  1: jump request from `control`.
- `branch_cond`  in  1: branch condition from the datapath.
- `target`  in  PC_WIDTH: branch/jump target from the datapath.
- `stall`  in  1: datapath busy (for example, a load in flight); holds the EXEC state.
- `retire`  out  1: one-cycle pulse when an instruction completes.
- `halted`  out  1: the processor has stopped.
- `pc`  out  PC_WIDTH: current PC.
- `retired_count`  out  16: number of retired instructions, saturating.

## Operation
- The FSM states are FETCH, LATCH, DECODE, EXEC and HALTED.
- FETCH:
  - `imem_en`=1 and `imem_addr`=`pc`.
  - Next state is LATCH.
- LATCH:
  - The instruction register captures `imem_data`.
  - The field outputs update at the end of this cycle.
  - Next state is DECODE.
- DECODE:
  - `instr_valid`=1.
  - `control` registers its outputs on this edge.
  - Next state is EXEC.
- EXEC:
  - `instr_valid`=1.
  - If `stall`=1, the block stays in EXEC and changes no state.
  - Otherwise the next PC is chosen with this priority:
    - `halt`: go to HALTED, PC unchanged.
    - `jump`: PC ← `target`.
    - `branch` && `branch_cond`: PC ← `target`.
    - Otherwise: PC ← PC+1, wrapping modulo 2^PC_WIDTH (0xFF → 0x00).
  - `retire` pulses on the completing cycle, including the cycle that takes a halt.
  - Next state is FETCH, or HALTED when halt is taken.
- HALTED:
  - `halted`=1 and `imem_en`=0.
  - The block stays in HALTED until `reset`. All other inputs are ignored.
- `branch`, `jump` and `halt` are sampled only in EXEC. `control` must present per-instruction values in that cycle. Values of these inputs in any other state have no effect.
- `branch`=1 with `branch_cond`=0 falls through to PC+1.
- `retired_count` increments on each `retire` and saturates at 0xFFFF.

## Timing
- Reset values:
  - State FETCH.
  - `pc`=`RESET_PC`.
  - Instruction register = 0, so `format`/`opcode`/`sign`/`operand` = 0.
  - `instr_valid`=0, `retire`=0, `halted`=0, `retired_count`=0.
  - `imem_en`=0 during the reset cycle, and 1 in the first cycle after reset is released.
- Latency with no stall: 4 cycles per instruction. Retire happens on cycle 4, and the next FETCH is on cycle 5.
- A stall of N cycles adds N cycles. The fields stay stable and `instr_valid` stays high throughout the stall.
- Reset asserted mid-instruction, in any state including HALTED, abandons that instruction. The next cycle is FETCH at `RESET_PC` with no `retire` pulse.
- `pc` is updated on the EXEC edge. `imem_addr` shows the new value in the following FETCH cycle.

## Structure
- A shared package `cpu_pkg` holds:
  - Opcode constants: OP_ADD 3'b000, OP_LOAD 3'b001, OP_STORE 3'b010, OP_EPAR 3'b100, OP_CP 3'b111, OP_JUMP 4'b0011, OP_BRANCH 4'b0100, OP_HALT 4'b1011.
  - Instruction field bit positions.
  - The fetch state encoding.
- There is one sub-module, `pc_unit`. It contains the PC register, the increment/target mux and the wrap logic.
- The FSM, instruction register and retire counter stay in `fetch_unit`.

## Test plan
- Sequential run:
  - Stimulus: reset, then imem holds non-control instructions at 0..3.
  - Required: `imem_addr` sequence 0,1,2,3, one retire every 4 cycles, `retired_count`=4 after 16 cycles.
- Jump:
  - Stimulus: `jump`=1 in EXEC with `target`=0x40.
  - Required: next FETCH `imem_addr`=0x40.
- Branch resolution:
  - Stimulus: `branch`=1, `branch_cond`=0 at PC 0x10, then `branch`=1, `branch_cond`=1 with `target`=0x05.
  - Required: first instruction continues to PC 0x11, second goes to 0x05.
- Halt plus stall:
  - Stimulus: `stall` held for 3 EXEC cycles, then `halt`=1.
  - Required: EXEC lasts 4 cycles, one retire pulse, `halted`=1 stays high, `imem_en`=0, PC frozen.
- Wrap and mid-operation reset:
  - Stimulus: PC 0xFF with a plain instruction.
  - Required: next PC is 0x00.
  - Stimulus: `reset` in DECODE.
  - Required: next cycle is FETCH at `RESET_PC`, no retire pulse, counter cleared.
- Saturation:
  - Stimulus: preload `retired_count` to 0xFFFE via a force, then retire 3 instructions.
  - Required: `retired_count` reads 0xFFFF.
